// File: rtl/sdram_arb_pkg.sv
// Shared types and IDs for the two-requester SDRAM arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
  typedef logic arb_id_t;
  localparam arb_id_t ID_M0 = 1'b0;
  localparam arb_id_t ID_M1 = 1'b1;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// Push on full and pop on empty are ignored.
module arb_id_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  arb_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output arb_id_t head
);
  localparam int AW = $clog2(DEPTH);

  arb_id_t        mem_q [DEPTH];
  arb_id_t        mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           do_push, do_pop;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Pointer/occupancy update; depth is a power of 2 so pointers wrap naturally.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = push_id;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // State registers; storage needs no reset since occupancy gates it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM port between the video
// reader (m0) and the stream writer (m1), with a bounded hold window and
// in-order read-data routing. Optional counters under SDRAM_ARB_STATS_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_W      = 32,
  parameter int MAX_PENDING = 8,
  parameter int HOLD_MAX    = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic [ADDR_W-1:0]       m0_address,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [8*DATA_BYTES-1:0] m0_writedata,
  input  logic [DATA_BYTES-1:0]   m0_byteenable,
  output logic                    m0_waitrequest,
  output logic [8*DATA_BYTES-1:0] m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic [ADDR_W-1:0]       m1_address,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [8*DATA_BYTES-1:0] m1_writedata,
  input  logic [DATA_BYTES-1:0]   m1_byteenable,
  output logic                    m1_waitrequest,
  output logic [8*DATA_BYTES-1:0] m1_readdata,
  output logic                    m1_readdatavalid,
  output logic [ADDR_W-1:0]       s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [8*DATA_BYTES-1:0] s_writedata,
  output logic [DATA_BYTES-1:0]   s_byteenable,
  input  logic                    s_waitrequest,
  input  logic [8*DATA_BYTES-1:0] s_readdata,
  input  logic                    s_readdatavalid
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [31:0]             m0_cmd_count,
  output logic [31:0]             m1_cmd_count,
  output logic [31:0]             stall_count
`endif
);
  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_t    state_q, state_d;
  logic          ptr_q, ptr_d;          // 0 favours m0, 1 favours m1
  logic [HW-1:0] hold_q, hold_d;
  logic          req0, req1, gnt_req, oth_req, accept, hold_hit;
  logic          fifo_full, fifo_empty;
  arb_id_t       gnt_id, head_id;

  assign req0   = m0_read | m0_write;
  assign req1   = m1_read | m1_write;
  assign gnt_id = (state_q == GNT1) ? ID_M1 : ID_M0;
  assign accept = (s_read | s_write) & ~s_waitrequest;

  // Command mux: granted requester drives the SDRAM port; reads stall on a full ID FIFO.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      GNT0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~fifo_full;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest | (m0_read & fifo_full);
      end
      GNT1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~fifo_full;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest | (m1_read & fifo_full);
      end
      default: ;
    endcase
  end

  // Grant FSM: release when the owner goes quiet or fills its hold window.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_req  = (gnt_id == ID_M1) ? req1 : req0;
    oth_req  = (gnt_id == ID_M1) ? req0 : req1;
    hold_hit = accept && (hold_q == HW'(HOLD_MAX - 1));
    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || !ptr_q)) state_d = GNT0;
        else if (req1)                 state_d = GNT1;
      end
      GNT0, GNT1: begin
        if (!gnt_req || hold_hit) begin
          ptr_d  = ~gnt_id;
          hold_d = '0;
          if (oth_req)      state_d = (gnt_id == ID_M0) ? GNT1 : GNT0;
          else if (!gnt_req) state_d = IDLE;
        end else begin
          hold_d = hold_q + HW'(accept);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  arb_id_fifo #(.DEPTH(MAX_PENDING)) u_id_fifo (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .push    (accept & s_read),
    .push_id (gnt_id),
    .pop     (s_readdatavalid),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head_id)
  );

  // Read data is broadcast; only the owner of the FIFO head sees valid.
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = s_readdatavalid & ~fifo_empty & (head_id == ID_M0);
  assign m1_readdatavalid = s_readdatavalid & ~fifo_empty & (head_id == ID_M1);

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d, stall_q, stall_d;

  assign m0_cmd_count = m0_cnt_q;
  assign m1_cmd_count = m1_cnt_q;
  assign stall_count  = stall_q;

  // Free-running counters of accepted commands and unserved request cycles.
  always_comb begin
    m0_cnt_d = m0_cnt_q + 32'(accept && gnt_id == ID_M0);
    m1_cnt_d = m1_cnt_q + 32'(accept && gnt_id == ID_M1);
    stall_d  = stall_q + 32'((req0 | req1) & ~accept);
  end

  // Statistics registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      m0_cnt_q <= '0;
      m1_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      m0_cnt_q <= m0_cnt_d;
      m1_cnt_q <= m1_cnt_d;
      stall_q  <= stall_d;
    end
  end
`endif

`ifndef SYNTHESIS
  // Read and write together from one requester is a protocol violation.
  always @(posedge sys_clk) begin
    if (!sys_rst) begin
      assert (!(m0_read && m0_write));
      assert (!(m1_read && m1_write));
    end
  end
`endif
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: master drivers, an SDRAM slave model
// returning data derived from the address, and a monitor checking routing.
module tb_sdram_arbiter;
  localparam int DB = 4, AW = 32, DW = 32, MP = 8, HM = 4;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic          m_read [2], m_write [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DB-1:0] m_be [2];
  wire  [1:0]    m_wait, m_rdv;
  wire  [DW-1:0] m0_rdata, m1_rdata;
  wire  [AW-1:0] s_address;
  wire           s_read, s_write;
  wire  [DW-1:0] s_writedata;
  wire  [DB-1:0] s_byteenable;
  logic          s_wait_rnd = 1'b0, force_wait = 1'b0;
  wire           s_waitrequest = s_wait_rnd | force_wait;
  logic [DW-1:0] s_readdata = '0;
  logic          s_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
  wire  [31:0]   st_m0, st_m1, st_stall;
`endif

  sdram_arbiter #(.DATA_BYTES(DB), .ADDR_W(AW), .MAX_PENDING(MP), .HOLD_MAX(HM)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]), .m0_waitrequest(m_wait[0]),
    .m0_readdata(m0_rdata), .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]), .m1_waitrequest(m_wait[1]),
    .m1_readdata(m1_rdata), .m1_readdatavalid(m_rdv[1]),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
`ifdef SDRAM_ARB_STATS_EN
    , .m0_cmd_count(st_m0), .m1_cmd_count(st_m1), .stall_count(st_stall)
`endif
  );

  typedef struct { bit o; logic [31:0] d; } rd_t;
  typedef struct { logic [31:0] d; int due; } sr_t;
  rd_t oq[$];          // reference: outstanding reads in issue order
  sr_t sq[$];          // SDRAM model pending returns
  bit  acc_log[$];
  int  n_vec = 0, n_err = 0, cyc = 0, lat = 3, wait_pct = 0, stray = 0;
  int  rv_cnt[2] = '{0, 0};
  bit  withhold = 0, log_en = 0, t5_ok = 0, t5_done = 0;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return 32'hAAAA0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SDRAM model: random stall, fixed-latency in-order returns, stray pulses.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    s_wait_rnd      = ($urandom_range(0, 99) < wait_pct);
    s_readdatavalid = 1'b0;
    s_readdata      = $urandom;
    if (stray > 0) begin
      s_readdatavalid = 1'b1;
      stray--;
    end else if (!withhold && sq.size() > 0 && sq[0].due <= cyc) begin
      s_readdata      = sq[0].d;
      s_readdatavalid = 1'b1;
      void'(sq.pop_front());
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) sq.delete();
    else if (s_read && !s_waitrequest) sq.push_back('{rdat(s_address), cyc + lat});
  end

  // Monitor: read routing against the reference queue, command forwarding.
  initial begin
    rd_t r;
    bit  o, h0, h1, s_acc;
    forever begin
      @(negedge clk);
      if (rst) begin
        oq.delete();
        continue;
      end
      if (s_readdatavalid) begin
        if (oq.size() > 0) begin
          r = oq.pop_front();
          chk("rdv_owner", 64'(m_rdv), r.o ? 64'h2 : 64'h1);
          chk("rdata", r.o ? m1_rdata : m0_rdata, r.d);
          if (m_rdv[r.o]) rv_cnt[r.o]++;
        end else begin
          chk("rdv_empty", 64'(m_rdv), 0);
        end
      end else if (m_rdv != 2'b00) begin
        chk("rdv_spurious", 64'(m_rdv), 0);
      end
      s_acc = (s_read | s_write) & ~s_waitrequest;
      h0    = (m_read[0] | m_write[0]) & ~m_wait[0];
      h1    = (m_read[1] | m_write[1]) & ~m_wait[1];
      if (s_acc || h0 || h1) begin
        o = h1;
        chk("handshake", {s_acc, h0 ^ h1}, 2'b11);
        chk("s_address", s_address, m_addr[o]);
        chk("s_rw", {s_read, s_write}, {m_read[o], m_write[o]});
        chk("s_be", s_byteenable, m_be[o]);
        if (m_write[o]) chk("s_wdata", s_writedata, m_wdata[o]);
        if (log_en) acc_log.push_back(o);
        if (s_acc && s_read) oq.push_back('{o, rdat(m_addr[o])});
      end
    end
  end

  task automatic do_cmd(input int n, input bit rd, input logic [31:0] a, input int lim, output bit ok);
    m_addr[n]  = a;
    m_wdata[n] = $urandom;
    m_be[n]    = DB'($urandom_range(1, 15));
    m_read[n]  = rd;
    m_write[n] = !rd;
    ok = 0;
    for (int t = 0; t < lim; t++) begin
      @(negedge clk);
      if (!m_wait[n]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    m_read[n]  = 1'b0;
    m_write[n] = 1'b0;
  endtask

  task automatic run_cmds(input int n, input int cnt, input bit rnd, input logic [31:0] base);
    bit ok;
    int g;
    for (int i = 0; i < cnt; i++) begin
      if (rnd) do_cmd(n, 1'($urandom), $urandom & 32'hFFFF_FFFC, 400, ok);
      else     do_cmd(n, 1'b0, base + 32'(4 * i), 400, ok);
      chk($sformatf("cmd_accept_m%0d", n), 64'(ok), 1);
      if (rnd) begin
        g = $urandom_range(0, 2);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && oq.size() > 0; t++) @(negedge clk);
    chk("drain", 64'(oq.size()), 0);
  endtask

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    bit ok;
    int acc, c0, bad, b0, b1;
    for (int i = 0; i < 2; i++) begin
      m_read[i] = 0; m_write[i] = 0; m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state held with no requests, then first-read latency.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_wait", 64'(m_wait), 64'h3);
      chk("rst_cmd", {s_read, s_write}, 2'b00);
      chk("rst_rdv", 64'(m_rdv), 0);
    end
    chk("rst_addr", s_address, 0);
    @(posedge clk); #1;
    m_addr[0] = 32'h100; m_be[0] = 4'hF; m_read[0] = 1'b1;
    @(negedge clk);
    chk("idle_latency", 64'(s_read), 0);
    @(negedge clk);
    chk("first_read", {s_read, s_address}, {1'b1, 32'h100});
    @(posedge clk); #1 m_read[0] = 1'b0;
    drain();

    // Continuous writes from both: runs of HOLD_MAX alternate.
    acc_log.delete(); log_en = 1;
    fork
      run_cmds(0, 32, 0, 32'h1000);
      run_cmds(1, 32, 0, 32'h2000);
    join
    log_en = 0;
    chk("alt_total", 64'(acc_log.size()), 64);
    c0 = 0; bad = 0;
    foreach (acc_log[i]) begin
      if (!acc_log[i]) c0++;
      if (i > 0 && acc_log[i] != ((i % HM == 0) ? !acc_log[i-1] : acc_log[i-1])) bad++;
    end
    chk("alt_m0_count", 64'(c0), 32);
    chk("alt_pattern", 64'(bad), 0);

    // Interleaved reads routed back to their issuers.
    lat = 3; b0 = rv_cnt[0]; b1 = rv_cnt[1];
    fork
      begin do_cmd(0, 1, 32'h10, 50, ok); chk("rd_m0_acc", 64'(ok), 1); end
      begin @(posedge clk); #1; do_cmd(1, 1, 32'h20, 50, ok); chk("rd_m1_acc", 64'(ok), 1); end
    join
    drain();
    chk("rdv_once_m0", 64'(rv_cnt[0] - b0), 1);
    chk("rdv_once_m1", 64'(rv_cnt[1] - b1), 1);

    // Withheld returns: ID FIFO fills at MAX_PENDING, writes still pass.
    withhold = 1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      do_cmd(0, 1, 32'h40 + 32'(4 * i), 12, ok);
      acc += int'(ok);
    end
    chk("full_accepted", 64'(acc), MP);
    m_addr[0] = 32'h80; m_read[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_wait_m0", {m_wait[0], s_read}, 2'b10);
    end
    @(posedge clk); #1 m_read[0] = 1'b0;
    do_cmd(1, 0, 32'h500, 50, ok);
    chk("full_m1_write", 64'(ok), 1);
    do_cmd(0, 0, 32'h504, 50, ok);
    chk("full_m0_write", 64'(ok), 1);
    withhold = 0;
    drain();

    // SDRAM stall mid-burst: no grant switch, address stable.
    do_cmd(0, 0, 32'h2F0, 50, ok);
    force_wait = 1'b1;
    m_addr[0] = 32'h300; m_wdata[0] = 32'h5555_0300; m_be[0] = 4'hF; m_write[0] = 1'b1;
    fork
      begin do_cmd(1, 0, 32'h400, 100, t5_ok); t5_done = 1; end
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {s_write, s_address, m_wait}, {1'b1, 32'h300, 2'b11});
    end
    @(posedge clk); #1 force_wait = 1'b0;
    @(negedge clk);
    chk("stall_release", {s_write, s_address, m_wait}, {1'b1, 32'h300, 2'b10});
    @(posedge clk); #1 m_write[0] = 1'b0;
    for (int t = 0; t < 100 && !t5_done; t++) @(negedge clk);
    chk("stall_m1_after", 64'(t5_ok), 1);

    // Reset with reads pending; stray returns are dropped.
    withhold = 1;
    for (int i = 0; i < 3; i++) do_cmd(0, 1, 32'h600 + 32'(4 * i), 50, ok);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; stray = 2; withhold = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stray_rdv", 64'(m_rdv), 0);
      chk("post_rst_idle", {m_wait, s_read, s_write}, 4'b1100);
    end
    do_cmd(1, 1, 32'h700, 50, ok);
    do_cmd(0, 1, 32'h704, 50, ok);
    drain();

    // Randomized mixed traffic with SDRAM stalls and varying latency.
    for (int p = 0; p < 3; p++) begin
      wait_pct = 10 + 20 * p;
      lat = $urandom_range(1, 6);
      fork
        run_cmds(0, 30, 1, 0);
        run_cmds(1, 30, 1, 0);
      join
      wait_pct = 0;
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
